seq_control: RTL and testbench

- Instruction controller that sits beside the 24-step relay sequencer (FSA).
- Latches the fetched opcode and decodes it into an instruction class with a fixed step length (8/10/12/14/24).
- Drives the sequencer's early-abort lines, emits per-step datapath strobes, evaluates GOTO conditions, and owns the run/halt state of the machine.

---
 rtl/seq_control_if.sv | 42 ++++
 rtl/seq_control.sv | 211 +++++++++++++++++++++
 tb/tb_seq_control.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_control_if.sv
// rtl/seq_control_if.sv - Signal bundle between seq_control and the 24-step relay sequencer
interface seq_control_if #(
    parameter int NSTEPS = 24,
    parameter int DW     = 8
);
    localparam int SW = $clog2(NSTEPS);

    // Sequencer / datapath side
    logic [SW-1:0] step;
    logic          step_strobe;
    logic [DW-1:0] data_in;
    logic          flag_z;
    logic          flag_c;
    logic          flag_s;
    logic          run_req;
    logic          halt_req;

    // Controller side
    logic          seq_enable;
    logic [3:0]    abort;
    logic          mem_read;
    logic          ir_load;
    logic          inc_load;
    logic          pc_load;
    logic          reg_load;
    logic [2:0]    dst_sel;
    logic [2:0]    src_sel;
    logic          goto_taken;
    logic          halted;

    modport master (
        output step, step_strobe, data_in, flag_z, flag_c, flag_s, run_req, halt_req,
        input  seq_enable, abort, mem_read, ir_load, inc_load, pc_load, reg_load,
               dst_sel, src_sel, goto_taken, halted
    );

    modport slave (
        input  step, step_strobe, data_in, flag_z, flag_c, flag_s, run_req, halt_req,
        output seq_enable, abort, mem_read, ir_load, inc_load, pc_load, reg_load,
               dst_sel, src_sel, goto_taken, halted
    );
endinterface

// File: rtl/seq_control.sv
// rtl/seq_control.sv - Instruction controller: opcode latch/decode, step strobes, abort, GOTO and run/halt FSM
module seq_control #(
    parameter int NSTEPS = 24,
    parameter int DW     = 8
) (
    input logic         clock,
    input logic         reset,
    seq_control_if.slave bus
);
    localparam int SW = $clog2(NSTEPS);
    localparam logic [SW-1:0] LAST_STEP = SW'(NSTEPS - 1);

    typedef enum logic [1:0] {
        S_HALTED   = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } run_state_t;

    typedef enum logic [3:0] {
        C_MOV8, C_SETAB, C_ALU, C_LOAD, C_STORE,
        C_MOV16, C_HALT, C_INCXY, C_GOTO, C_NOP
    } iclass_t;

    run_state_t    state;
    run_state_t    state_next;
    logic          run_q;
    logic          run_rise;

    logic [DW-1:0] ir;
    iclass_t       iclass;
    logic [SW-1:0] last_step;
    logic [3:0]    abort_code;

    logic [SW-1:0] cur;
    logic          stb;
    logic          stb_final;
    logic          stb_halt_insn;
    logic          at_s0, at_s3, at_s5, at_s6, at_s7, at_s9, at_s11, at_s22;
    logic          fetch_rd;
    logic          goto_cond;
    logic          reg_load_hit;

    logic          mem_read_q;
    logic          ir_load_q;
    logic          inc_load_q;
    logic          pc_load_q;
    logic          reg_load_q;
    logic          goto_q;

    // ------------------------------------------------------------------
    // Step qualification: out-of-range steps and any strobe while halted
    // are treated as if no strobe arrived.
    // ------------------------------------------------------------------
    assign cur       = bus.step;
    assign stb       = bus.step_strobe && (cur <= LAST_STEP) && (state != S_HALTED);
    assign at_s0     = stb && (cur == SW'(0));
    assign at_s3     = stb && (cur == SW'(3));
    assign at_s5     = stb && (cur == SW'(5));
    assign at_s6     = stb && (cur == SW'(6));
    assign at_s7     = stb && (cur == SW'(7));
    assign at_s9     = stb && (cur == SW'(9));
    assign at_s11    = stb && (cur == SW'(11));
    assign at_s22    = stb && (cur == SW'(22));
    assign fetch_rd  = stb && (cur >= SW'(1)) && (cur <= SW'(4));
    assign stb_final = stb && (cur == last_step);
    assign stb_halt_insn = at_s9 && (iclass == C_HALT);
    assign run_rise  = bus.run_req && !run_q;

    // ------------------------------------------------------------------
    // Opcode decode (first matching pattern wins, so HALT precedes MOV16)
    // ------------------------------------------------------------------
    always_comb begin
        iclass = C_NOP;
        casez (ir[7:0])
            8'b00??????: iclass = C_MOV8;
            8'b01??????: iclass = C_SETAB;
            8'b1000????: iclass = C_ALU;
            8'b1001????: iclass = ir[3] ? C_STORE : C_LOAD;
            8'b10101110: iclass = C_HALT;
            8'b1010????: iclass = C_MOV16;
            8'b10110000: iclass = C_INCXY;
            8'b11??????: iclass = C_GOTO;
            default:     iclass = C_NOP;
        endcase
    end

    always_comb begin
        last_step  = SW'(7);
        abort_code = 4'b0001;
        case (iclass)
            C_LOAD, C_STORE: begin
                last_step  = SW'(11);
                abort_code = 4'b0100;
            end
            C_MOV16, C_HALT: begin
                last_step  = SW'(9);
                abort_code = 4'b0010;
            end
            C_INCXY: begin
                last_step  = SW'(13);
                abort_code = 4'b1000;
            end
            C_GOTO: begin
                last_step  = LAST_STEP;
                abort_code = 4'b0000;
            end
            default: begin
                last_step  = SW'(7);
                abort_code = 4'b0001;
            end
        endcase
    end

    always_comb begin
        reg_load_hit = 1'b0;
        case (iclass)
            C_MOV8, C_SETAB, C_ALU: reg_load_hit = at_s7;
            C_LOAD:                 reg_load_hit = at_s11;
            C_MOV16:                reg_load_hit = at_s9;
            default:                reg_load_hit = 1'b0;
        endcase
    end

    // All-zero condition field means an unconditional branch
    assign goto_cond = (ir[4:1] == 4'b0000)
                     | (ir[4] & bus.flag_s)
                     | (ir[3] & ~bus.flag_z)
                     | (ir[2] & bus.flag_c)
                     | (ir[1] & bus.flag_z);

    // ------------------------------------------------------------------
    // Run FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_HALTED;
            run_q <= 1'b0;
        end else begin
            state <= state_next;
            run_q <= bus.run_req;
        end
    end

    // Run FSM: next state. A stop request landing on the final step goes
    // straight to HALTED so halt_req and HALT decode never double-step.
    always_comb begin
        state_next = state;
        case (state)
            S_HALTED: begin
                if (run_rise) state_next = S_RUN;
            end
            S_RUN: begin
                if (bus.halt_req || stb_halt_insn)
                    state_next = stb_final ? S_HALTED : S_STOPPING;
            end
            S_STOPPING: begin
                if (stb_final) state_next = S_HALTED;
            end
            default: state_next = S_HALTED;
        endcase
    end

    // Run FSM: outputs
    always_comb begin
        bus.seq_enable = 1'b0;
        bus.halted     = 1'b0;
        bus.abort      = 4'b0000;
        case (state)
            S_RUN, S_STOPPING: begin
                bus.seq_enable = 1'b1;
                if (cur == last_step) bus.abort = abort_code;
            end
            default: bus.halted = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered datapath strobes, instruction register and branch latch
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_read_q <= 1'b0;
            ir_load_q  <= 1'b0;
            inc_load_q <= 1'b0;
            pc_load_q  <= 1'b0;
            reg_load_q <= 1'b0;
            goto_q     <= 1'b0;
            ir         <= '0;
        end else begin
            mem_read_q <= fetch_rd;
            ir_load_q  <= at_s3;
            inc_load_q <= at_s5;
            pc_load_q  <= at_s6 || (at_s22 && goto_q);
            reg_load_q <= reg_load_hit;
            if (at_s3) ir <= bus.data_in;
            if (at_s0)
                goto_q <= 1'b0;
            else if (at_s7 && (iclass == C_GOTO))
                goto_q <= goto_cond;
        end
    end

    assign bus.mem_read   = mem_read_q;
    assign bus.ir_load    = ir_load_q;
    assign bus.inc_load   = inc_load_q;
    assign bus.pc_load    = pc_load_q;
    assign bus.reg_load   = reg_load_q;
    assign bus.goto_taken = goto_q;
    assign bus.dst_sel    = ir[5:3];
    assign bus.src_sel    = ir[2:0];
endmodule

// File: tb/tb_seq_control.sv
// tb/tb_seq_control.sv - Self-checking bench for seq_control with a behavioural instruction model
module tb_seq_control;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic       model_halted;
    logic [3:0] obs_abort  [0:23];
    logic [4:0] obs_strobe [0:23];

    seq_control_if #(.NSTEPS(24), .DW(8)) sif ();

    seq_control #(.NSTEPS(24), .DW(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int ref_len(input logic [7:0] op);
        if (op[7] == 1'b0)      return 8;
        if (op[7:6] == 2'b11)   return 24;
        if (op[7:4] == 4'h8)    return 8;
        if (op[7:4] == 4'h9)    return 12;
        if (op[7:4] == 4'hA)    return 10;
        if (op == 8'hB0)        return 14;
        return 8;
    endfunction

    function automatic int ref_reg_step(input logic [7:0] op);
        if (op[7] == 1'b0)                   return 7;
        if (op[7:4] == 4'h8)                 return 7;
        if (op[7:4] == 4'h9)                 return op[3] ? -1 : 11;
        if (op[7:4] == 4'hA && op != 8'hAE)  return 9;
        return -1;
    endfunction

    function automatic logic [3:0] ref_abort(input int len);
        case (len)
            8:       return 4'b0001;
            10:      return 4'b0010;
            12:      return 4'b0100;
            14:      return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // Plays the sequencer through one instruction (steps 0..min(len-1,last)),
    // two clocks per step, checking every output against the model.
    task automatic run_instr(input logic [7:0] op, input logic fz, input logic fc,
                             input logic fs, input int halt_at, input int last);
        int len, rstep;
        logic is_goto, gt, exp_h;
        logic [3:0] exp_ab;
        logic [4:0] exp_p, got_p;
        len   = ref_len(op);
        rstep = ref_reg_step(op);
        is_goto = (op[7:6] == 2'b11);
        gt = is_goto && ((op[4:1] == 4'b0000) || (op[4] && fs) || (op[3] && !fz) ||
                         (op[2] && fc) || (op[1] && fz));
        sif.flag_z = fz;
        sif.flag_c = fc;
        sif.flag_s = fs;
        for (int i = 0; i < 24; i++) begin
            obs_abort[i]  = 4'b0;
            obs_strobe[i] = 5'b0;
        end
        for (int k = 0; k < len && k <= last; k++) begin
            @(negedge clock);
            sif.step        = 5'(k);
            sif.step_strobe = 1'b1;
            sif.data_in     = (k == 3) ? op : 8'($urandom);
            if (k == halt_at) sif.halt_req = 1'b1;
            #1;
            got_p = {sif.mem_read, sif.ir_load, sif.inc_load, sif.pc_load, sif.reg_load};
            n_cmp++;
            if (got_p !== 5'b0) begin
                n_err++;
                $display("FAIL pulse_width op=%h step=%0d: got %b expected 00000", op, k, got_p);
            end
            exp_ab = (k == len - 1) ? ref_abort(len) : 4'b0000;
            obs_abort[k] = sif.abort;
            n_cmp++;
            if (sif.abort !== exp_ab) begin
                n_err++;
                $display("FAIL abort op=%h step=%0d: got %b expected %b", op, k, sif.abort, exp_ab);
            end
            @(negedge clock);
            sif.step_strobe = 1'b0;
            exp_p = {(k >= 1 && k <= 4), (k == 3), (k == 5), (k == 6 || (k == 22 && gt)), (k == rstep)};
            got_p = {sif.mem_read, sif.ir_load, sif.inc_load, sif.pc_load, sif.reg_load};
            obs_strobe[k] = got_p;
            n_cmp++;
            if (got_p !== exp_p) begin
                n_err++;
                $display("FAIL strobes op=%h step=%0d: got %b expected %b", op, k, got_p, exp_p);
            end
            if (k >= 4) begin
                n_cmp++;
                if ({sif.dst_sel, sif.src_sel} !== op[5:0]) begin
                    n_err++;
                    $display("FAIL operands op=%h step=%0d: got %h expected %h", op, k,
                             {sif.dst_sel, sif.src_sel}, op[5:0]);
                end
            end
            n_cmp++;
            if (sif.goto_taken !== ((k >= 7) ? gt : 1'b0)) begin
                n_err++;
                $display("FAIL goto_taken op=%h step=%0d: got %b expected %b", op, k,
                         sif.goto_taken, (k >= 7) ? gt : 1'b0);
            end
            exp_h = (k == len - 1) && (halt_at <= k || op == 8'hAE);
            n_cmp++;
            if ({sif.halted, sif.seq_enable} !== {exp_h, !exp_h}) begin
                n_err++;
                $display("FAIL run_state op=%h step=%0d: got halted/en=%b%b expected %b%b", op, k,
                         sif.halted, sif.seq_enable, exp_h, !exp_h);
            end
            model_halted = exp_h;
        end
        sif.halt_req = 1'b0;
    endtask

    task automatic run_pulse();
        @(negedge clock);
        sif.run_req = 1'b1;
        @(negedge clock);
        sif.run_req = 1'b0;
        n_cmp++;
        if ({sif.seq_enable, sif.halted} !== 2'b10) begin
            n_err++;
            $display("FAIL run_start: got en/halted=%b%b expected 10", sif.seq_enable, sif.halted);
        end
        model_halted = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] outs;
        reset = 1'b1;
        sif.step = '0; sif.step_strobe = 1'b0; sif.data_in = '0;
        sif.flag_z = 1'b0; sif.flag_c = 1'b0; sif.flag_s = 1'b0;
        sif.run_req = 1'b0; sif.halt_req = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        outs = {sif.seq_enable, sif.abort, sif.mem_read, sif.ir_load, sif.inc_load, sif.pc_load,
                sif.reg_load, sif.dst_sel, sif.src_sel, sif.goto_taken, sif.halted};
        n_cmp++;
        if (outs !== 18'h00001) begin
            n_err++;
            $display("FAIL reset_state: got %h expected 00001", outs);
        end
    endtask

    task automatic test_halted_ignored();
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            sif.step = 5'(k); sif.step_strobe = 1'b1; sif.data_in = 8'hC0;
            #1;
            n_cmp++;
            if (sif.abort !== 4'b0) begin
                n_err++;
                $display("FAIL halted_abort step=%0d: got %b expected 0000", k, sif.abort);
            end
            @(negedge clock);
            sif.step_strobe = 1'b0;
            n_cmp++;
            if ({sif.mem_read, sif.ir_load, sif.inc_load, sif.pc_load, sif.reg_load,
                 sif.dst_sel, sif.src_sel, sif.seq_enable} !== 12'h0) begin
                n_err++;
                $display("FAIL halted_strobes step=%0d: got %b%b%b%b%b %h%h %b expected all zero", k,
                         sif.mem_read, sif.ir_load, sif.inc_load, sif.pc_load, sif.reg_load,
                         sif.dst_sel, sif.src_sel, sif.seq_enable);
            end
        end
    endtask

    task automatic test_mov8();
        run_pulse();
        run_instr(8'h0A, 1'b0, 1'b0, 1'b0, 99, 99);
        n_cmp++;
        if (obs_abort[7] !== 4'b0001 || obs_strobe[3][3] !== 1'b1 || obs_strobe[7][0] !== 1'b1) begin
            n_err++;
            $display("FAIL mov8_plan: got abort7=%b irl3=%b rl7=%b expected 0001 1 1",
                     obs_abort[7], obs_strobe[3][3], obs_strobe[7][0]);
        end
    endtask

    task automatic test_out_of_range();
        for (int k = 24; k <= 31; k++) begin
            @(negedge clock);
            sif.step = 5'(k); sif.step_strobe = 1'b1;
            #1;
            n_cmp++;
            if (sif.abort !== 4'b0) begin
                n_err++;
                $display("FAIL oor_abort step=%0d: got %b expected 0000", k, sif.abort);
            end
            @(negedge clock);
            sif.step_strobe = 1'b0;
            n_cmp++;
            if ({sif.mem_read, sif.ir_load, sif.inc_load, sif.pc_load, sif.reg_load, sif.halted} !== 6'b0) begin
                n_err++;
                $display("FAIL oor_strobes step=%0d: got %b%b%b%b%b halted=%b expected all zero", k,
                         sif.mem_read, sif.ir_load, sif.inc_load, sif.pc_load, sif.reg_load, sif.halted);
            end
        end
    endtask

    task automatic test_halt();
        run_instr(8'hAE, 1'b0, 1'b0, 1'b0, 99, 99);
        n_cmp++;
        if (obs_abort[9] !== 4'b0010 || sif.halted !== 1'b1 || sif.seq_enable !== 1'b0) begin
            n_err++;
            $display("FAIL halt_plan: got abort9=%b halted=%b en=%b expected 0010 1 0",
                     obs_abort[9], sif.halted, sif.seq_enable);
        end
        run_pulse();
    endtask

    task automatic test_goto();
        run_instr(8'hE8, 1'b0, 1'b0, 1'b0, 99, 99);
        n_cmp++;
        if (obs_strobe[22][1] !== 1'b1) begin
            n_err++;
            $display("FAIL goto_taken_pc: got pc_load22=%b expected 1", obs_strobe[22][1]);
        end
        run_instr(8'hE8, 1'b1, 1'b0, 1'b0, 99, 99);
        n_cmp++;
        if (obs_strobe[22][1] !== 1'b0 || sif.goto_taken !== 1'b0) begin
            n_err++;
            $display("FAIL goto_not_taken: got pc_load22=%b goto=%b expected 0 0",
                     obs_strobe[22][1], sif.goto_taken);
        end
    endtask

    task automatic test_incxy_store();
        logic any_rl;
        run_instr(8'hB0, 1'b0, 1'b0, 1'b0, 99, 99);
        n_cmp++;
        if (obs_abort[13] !== 4'b1000) begin
            n_err++;
            $display("FAIL incxy_abort: got %b expected 1000", obs_abort[13]);
        end
        run_instr(8'h98, 1'b0, 1'b0, 1'b0, 99, 99);
        any_rl = 1'b0;
        for (int k = 0; k < 12; k++) any_rl = any_rl | obs_strobe[k][0];
        n_cmp++;
        if (obs_abort[11] !== 4'b0100 || any_rl !== 1'b0) begin
            n_err++;
            $display("FAIL store_plan: got abort11=%b reg_load=%b expected 0100 0", obs_abort[11], any_rl);
        end
    endtask

    task automatic test_halt_req();
        run_instr(8'h0A, 1'b0, 1'b0, 1'b0, 2, 99);
        n_cmp++;
        if (obs_abort[7] !== 4'b0001 || sif.halted !== 1'b1) begin
            n_err++;
            $display("FAIL halt_req_plan: got abort7=%b halted=%b expected 0001 1", obs_abort[7], sif.halted);
        end
        run_pulse();
        run_instr(8'hBF, 1'b0, 1'b0, 1'b0, 99, 99);
        n_cmp++;
        if (obs_abort[7] !== 4'b0001) begin
            n_err++;
            $display("FAIL nop_len: got abort7=%b expected 0001", obs_abort[7]);
        end
    endtask

    task automatic test_random();
        logic [7:0] table_ops [0:11];
        logic [7:0] op;
        int len, hat;
        table_ops = '{8'h0A, 8'h4F, 8'h83, 8'h91, 8'h98, 8'hA5, 8'hAE, 8'hB0, 8'hC3, 8'hE8, 8'hF6, 8'hBF};
        for (int n = 0; n < 30; n++) begin
            op  = ($urandom_range(0, 1) == 0) ? 8'($urandom) : table_ops[$urandom_range(0, 11)];
            len = ref_len(op);
            hat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : 99;
            run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), hat, 99);
            if (model_halted) run_pulse();
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] outs;
        run_instr(8'hE8, 1'b0, 1'b0, 1'b0, 99, 15);
        #1;
        reset = 1'b1;
        #1;
        outs = {sif.seq_enable, sif.abort, sif.mem_read, sif.ir_load, sif.inc_load, sif.pc_load,
                sif.reg_load, sif.dst_sel, sif.src_sel, sif.goto_taken, sif.halted};
        n_cmp++;
        if (outs !== 18'h00001) begin
            n_err++;
            $display("FAIL reset_mid: got %h expected 00001", outs);
        end
        @(negedge clock);
        reset = 1'b0;
        sif.step = '0;
        run_pulse();
        run_instr(8'h0A, 1'b0, 1'b0, 1'b0, 99, 99);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_halted = 1'b1;
        test_reset();
        test_halted_ignored();
        test_mov8();
        test_out_of_range();
        test_halt();
        test_goto();
        test_incxy_store();
        test_halt_req();
        test_random();
        if (model_halted) run_pulse();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion, expected finish before time limit");
        $fatal(1, "bench time limit reached");
    end
endmodule
